// File: rtl/ic_pkg.sv
// -----------------------------------------------------------------------------
// ic_pkg
// Shared definitions for the incrementer/decrementer loop and its count holder.
//   N_DEFAULT     : default MSB index of the count bus (width N+1)
//   DEPTH_DEFAULT : default number of undo history entries
//   LVL_W         : width of the history level for the default depth
//   op_e          : per-cycle operation, already resolved by priority
//   decode_op()   : clear > restore > commit > hold
// -----------------------------------------------------------------------------
package ic_pkg;

   localparam int N_DEFAULT     = 7;
   localparam int DEPTH_DEFAULT = 4;
   localparam int LVL_W         = $clog2(DEPTH_DEFAULT) + 1;

   typedef enum logic [1:0] {
      OP_HOLD    = 2'd0,
      OP_COMMIT  = 2'd1,
      OP_RESTORE = 2'd2,
      OP_CLEAR   = 2'd3
   } op_e;

   // Lower-priority requests in the same cycle are dropped, never queued.
   function automatic op_e decode_op(input logic clear,
                                     input logic restore,
                                     input logic commit);
      if (clear)        return OP_CLEAR;
      else if (restore) return OP_RESTORE;
      else if (commit)  return OP_COMMIT;
      else              return OP_HOLD;
   endfunction

endpackage

// File: rtl/history_lifo.sv
// -----------------------------------------------------------------------------
// history_lifo
// Circular undo stack. A push stores i_din at the write pointer; once DEPTH
// entries are held the oldest one is silently overwritten. A pop steps the
// write pointer back. o_dout always presents the most recent entry so the
// owner can load it on the same edge as the pop.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : store i_din (ignored when i_pop or i_clear is also high)
//   i_pop      : discard the most recent entry (ignored when empty)
//   i_clear    : synchronous flush (pointer and level to zero)
//   i_din      : value to store
//   o_dout     : most recent entry
//   o_level    : number of valid entries, 0..DEPTH (registered)
//   o_empty    : level == 0 (registered)
//   o_full     : level == DEPTH (registered)
// -----------------------------------------------------------------------------
module history_lifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_clear,
   input  logic [W-1:0]            i_din,
   output logic [W-1:0]            o_dout,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_empty,
   output logic                    o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_nxt;
   logic             r_empty;
   logic             r_full;
   logic             w_do_push;

   // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH for free.
   assign w_rd_ptr  = r_wr_ptr - PTR_W'(1);
   assign o_dout    = r_mem[w_rd_ptr];
   assign w_do_push = i_push && !i_pop && !i_clear;

   // NOTE: every variable assigned here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_level_nxt  = r_level;
      if (i_clear) begin
         w_wr_ptr_nxt = '0;
         w_level_nxt  = '0;
      end else if (i_pop) begin
         if (r_level != '0) begin
            w_wr_ptr_nxt = w_rd_ptr;
            w_level_nxt  = r_level - LVL_W'(1);
         end
      end else if (i_push) begin
         w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
         // Level saturates at DEPTH; the oldest entry is overwritten instead.
         if (r_level != LVL_W'(DEPTH)) begin
            w_level_nxt = r_level + LVL_W'(1);
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample the pre-edge values together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_level  <= w_level_nxt;
         r_empty  <= (w_level_nxt == '0);
         r_full   <= (w_level_nxt == LVL_W'(DEPTH));
      end
   end

   // NOTE: the storage array has no reset; entries beyond level are never
   // read, so their contents do not matter.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   assign o_level = r_level;
   assign o_empty = r_empty;
   assign o_full  = r_full;

endmodule

// File: rtl/count_restore.sv
// -----------------------------------------------------------------------------
// count_restore
// Registered count holder with multi-level undo. o_count feeds the ic block,
// whose result returns as i_next_count. Every commit pushes the old count into
// the history; restore pops it back into the count.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_commit       : load i_next_count into the count
//   i_next_count   : candidate next value from ic
//   i_restore      : pop the most recent history entry into the count
//   i_clear        : synchronous clear of count and history
//   o_count        : current registered count
//   o_level        : number of valid history entries
//   o_empty        : level == 0
//   o_full         : level == DEPTH
//   o_restore_err  : one-cycle pulse after a restore requested while empty
// -----------------------------------------------------------------------------
module count_restore
   import ic_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_commit,
   input  logic [N:0]              i_next_count,
   input  logic                    i_restore,
   input  logic                    i_clear,
   output logic [N:0]              o_count,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_empty,
   output logic                    o_full,
   output logic                    o_restore_err
);

   op_e        w_op;
   logic       w_push;
   logic       w_pop;
   logic       w_hist_clear;
   logic       w_err;
   logic [N:0] w_hist_dout;
   logic [N:0] r_count;
   logic       r_restore_err;

   assign w_op         = decode_op(i_clear, i_restore, i_commit);
   assign w_hist_clear = (w_op == OP_CLEAR);
   assign w_push       = (w_op == OP_COMMIT);
   // A restore on an empty history changes nothing except raising the error.
   assign w_pop        = (w_op == OP_RESTORE) && !o_empty;
   assign w_err        = (w_op == OP_RESTORE) &&  o_empty;

   history_lifo #(
      .W     (N + 1),
      .DEPTH (DEPTH)
   ) u_history (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_hist_clear),
      .i_din   (r_count),
      .o_dout  (w_hist_dout),
      .o_level (o_level),
      .o_empty (o_empty),
      .o_full  (o_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count       <= '0;
         r_restore_err <= 1'b0;
      end else begin
         r_restore_err <= w_err;
         case (w_op)
            OP_CLEAR:   r_count <= '0;
            OP_RESTORE: if (w_pop) r_count <= w_hist_dout;
            OP_COMMIT:  r_count <= i_next_count;
            default:    r_count <= r_count;
         endcase
      end
   end

   assign o_count       = r_count;
   assign o_restore_err = r_restore_err;

endmodule

// File: tb/tb_count_restore.sv
// -----------------------------------------------------------------------------
// tb_count_restore
// Self-checking bench for count_restore (N = 7, DEPTH = 4). The reference model
// keeps the history as a queue of previous counts, capped at DEPTH entries.
// -----------------------------------------------------------------------------
module tb_count_restore;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic       commit;
   logic       restore;
   logic       clear;
   logic [7:0] next_drv;
   logic [7:0] next_count;
   logic       loop_en;
   logic [7:0] count;
   logic [2:0] level;
   logic       empty;
   logic       full;
   logic       restore_err;

   // Reference model state.
   logic [7:0] m_hist[$];
   logic [7:0] m_count;
   bit         m_err;

   int n_checks;
   int n_pass;

   // Closed loop with ic in +2 mode when loop_en is set.
   assign next_count = loop_en ? count + 8'd2 : next_drv;

   count_restore #(.N(7), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_commit      (commit),
      .i_next_count  (next_count),
      .i_restore     (restore),
      .i_clear       (clear),
      .o_count       (count),
      .o_level       (level),
      .o_empty       (empty),
      .o_full        (full),
      .o_restore_err (restore_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of requests, advance the model at the edge, sample #1 later.
   task automatic step(input bit c_clr, input bit c_rst, input bit c_cmt,
                       input logic [7:0] nxt);
      logic [7:0] nxt_eff;
      clear    = c_clr;
      restore  = c_rst;
      commit   = c_cmt;
      next_drv = nxt;
      nxt_eff  = loop_en ? m_count + 8'd2 : nxt;
      @(posedge clk);
      m_err = 1'b0;
      if (c_clr) begin
         m_hist.delete();
         m_count = 8'd0;
      end else if (c_rst) begin
         if (m_hist.size() == 0) m_err = 1'b1;
         else m_count = m_hist.pop_back();
      end else if (c_cmt) begin
         m_hist.push_back(m_count);
         if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
         m_count = nxt_eff;
      end
      #1;
      clear   = 1'b0;
      restore = 1'b0;
      commit  = 1'b0;
   endtask

   task automatic model_reset();
      m_hist.delete();
      m_count = 8'd0;
      m_err   = 1'b0;
   endtask

   task automatic test_reset();
      if (count !== 8'd0) $display("FAIL reset_count: got %0d want 0", count);
      else n_pass++;
      if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level);
      else n_pass++;
      if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty);
      else n_pass++;
      if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full);
      else n_pass++;
      if (restore_err !== 1'b0) $display("FAIL reset_err: got %b want 0", restore_err);
      else n_pass++;
      n_checks += 5;
   endtask

   task automatic test_basic();
      logic [7:0] exp_cnt[3];
      exp_cnt = '{8'd9, 8'd5, 8'd0};
      step(0, 0, 1, 8'd5);
      step(0, 0, 1, 8'd9);
      step(0, 0, 1, 8'd12);
      n_checks += 2;
      if (count !== 8'd12) $display("FAIL basic_count: got %0d want 12", count);
      else n_pass++;
      if (level !== 3'd3) $display("FAIL basic_level: got %0d want 3", level);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 8'd0);
         n_checks++;
         if (count !== exp_cnt[i])
            $display("FAIL basic_restore%0d: got %0d want %0d", i, count, exp_cnt[i]);
         else n_pass++;
      end
      n_checks++;
      if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty);
      else n_pass++;
   endtask

   task automatic test_restore_empty();
      step(0, 1, 0, 8'd77);
      n_checks += 3;
      if (restore_err !== 1'b1) $display("FAIL rempty_err: got %b want 1", restore_err);
      else n_pass++;
      if (count !== 8'd0) $display("FAIL rempty_count: got %0d want 0", count);
      else n_pass++;
      if (level !== 3'd0) $display("FAIL rempty_level: got %0d want 0", level);
      else n_pass++;
      step(0, 0, 0, 8'd0);
      n_checks++;
      if (restore_err !== 1'b0) $display("FAIL rempty_pulse: got %b want 0", restore_err);
      else n_pass++;
   endtask

   task automatic test_wrap_full();
      logic [7:0] exp_cnt[4];
      exp_cnt = '{8'd5, 8'd4, 8'd3, 8'd2};
      step(1, 0, 0, 8'd0);
      for (int v = 1; v <= 6; v++) step(0, 0, 1, 8'(v));
      n_checks += 2;
      if (full !== 1'b1) $display("FAIL wrap_full: got %b want 1", full);
      else n_pass++;
      if (level !== 3'd4) $display("FAIL wrap_level: got %0d want 4", level);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 8'd0);
         n_checks++;
         if (count !== exp_cnt[i])
            $display("FAIL wrap_restore%0d: got %0d want %0d", i, count, exp_cnt[i]);
         else n_pass++;
      end
      n_checks++;
      if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty);
      else n_pass++;
      step(0, 1, 0, 8'd0);
      n_checks += 2;
      if (restore_err !== 1'b1) $display("FAIL wrap_err: got %b want 1", restore_err);
      else n_pass++;
      if (count !== 8'd2) $display("FAIL wrap_err_count: got %0d want 2", count);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      step(1, 0, 0, 8'd0);
      step(0, 0, 1, 8'd7);
      step(0, 0, 1, 8'd8);
      step(0, 1, 1, 8'd99);
      n_checks += 2;
      if (count !== 8'd7) $display("FAIL same_rst_cmt_count: got %0d want 7", count);
      else n_pass++;
      if (level !== 3'd1) $display("FAIL same_rst_cmt_level: got %0d want 1", level);
      else n_pass++;
      step(1, 0, 1, 8'd55);
      n_checks += 3;
      if (count !== 8'd0) $display("FAIL same_clr_cmt_count: got %0d want 0", count);
      else n_pass++;
      if (level !== 3'd0) $display("FAIL same_clr_cmt_level: got %0d want 0", level);
      else n_pass++;
      if (empty !== 1'b1) $display("FAIL same_clr_cmt_empty: got %b want 1", empty);
      else n_pass++;
   endtask

   task automatic test_ic_loop();
      logic [7:0] exp_cnt[3];
      exp_cnt = '{8'hFE, 8'h00, 8'h02};
      step(1, 0, 0, 8'd0);
      step(0, 0, 1, 8'hFC);
      loop_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 8'd0);
         n_checks++;
         if (count !== exp_cnt[i])
            $display("FAIL loop_commit%0d: got %h want %h", i, count, exp_cnt[i]);
         else n_pass++;
      end
      step(0, 1, 0, 8'd0);
      n_checks++;
      if (count !== 8'h00) $display("FAIL loop_restore: got %h want 00", count);
      else n_pass++;
      loop_en = 1'b0;
   endtask

   task automatic test_async_reset();
      step(1, 0, 0, 8'd0);
      step(0, 0, 1, 8'd21);
      step(0, 0, 1, 8'd22);
      step(0, 0, 1, 8'd23);
      n_checks++;
      if (level !== 3'd3) $display("FAIL areset_pre_level: got %0d want 3", level);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      // First edge after release behaves as from reset: restore must fail.
      step(0, 1, 0, 8'd0);
      n_checks++;
      if (restore_err !== 1'b1) $display("FAIL areset_first_restore: got %b want 1", restore_err);
      else n_pass++;
   endtask

   task automatic test_random();
      bit         c_clr, c_rst, c_cmt;
      logic [7:0] nxt;
      int         bad;
      for (int i = 0; i < 400; i++) begin
         c_clr = ($urandom_range(0, 19) == 0);
         c_rst = ($urandom_range(0, 2) == 0);
         c_cmt = ($urandom_range(0, 1) == 1);
         nxt   = 8'($urandom);
         step(c_clr, c_rst, c_cmt, nxt);
         bad = 0;
         if (count !== m_count) bad++;
         if (level !== 3'(m_hist.size())) bad++;
         if (empty !== (m_hist.size() == 0)) bad++;
         if (full !== (m_hist.size() == DEPTH)) bad++;
         if (restore_err !== m_err) bad++;
         n_checks++;
         if (bad != 0)
            $display("FAIL random%0d: got cnt=%0d lvl=%0d e=%b f=%b err=%b want cnt=%0d lvl=%0d e=%b f=%b err=%b",
                     i, count, level, empty, full, restore_err,
                     m_count, m_hist.size(), (m_hist.size() == 0),
                     (m_hist.size() == DEPTH), m_err);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      commit   = 1'b0;
      restore  = 1'b0;
      clear    = 1'b0;
      next_drv = 8'd0;
      loop_en  = 1'b0;
      model_reset();
      #12;
      test_reset();
      rst_n = 1'b1;
      test_basic();
      test_restore_empty();
      test_wrap_full();
      test_same_cycle();
      test_ic_loop();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
